// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between the two producers, the round-robin arbiter and
// the shared consumer. The master side drives requests and consumer ready,
// and the slave side is the arbiter.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             i0_valid;
  logic [WIDTH-1:0] i0_data;
  logic             i0_ready;
  logic             i1_valid;
  logic [WIDTH-1:0] i1_data;
  logic             i1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;

  modport master (
    output i0_valid, i0_data, i1_valid, i1_data, out_ready,
    input  i0_ready, i1_ready, out_valid, out_data, sel
  );

  modport slave (
    input  i0_valid, i0_data, i1_valid, i1_data, out_ready,
    output i0_ready, i1_ready, out_valid, out_data, sel
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output word.
// The grant is recomputed every cycle from the current valids and the
// source of the last accepted word, so a withdrawn request leaves the
// fairness state untouched. Data only passes through registers, and the
// readies are the only combinational outputs.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux2_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             last_r;
  logic [WIDTH-1:0] data_r;
  logic             sel_r;

  logic             can_load_s;
  logic             gnt_valid_s;
  logic             gnt_s;
  logic             load_s;
  logic [WIDTH-1:0] gnt_data_s;

  // Grant selection, handshake readies and output-register next state.
  always_comb begin
    can_load_s   = 1'b0;
    gnt_valid_s  = 1'b0;
    gnt_s        = 1'b0;
    load_s       = 1'b0;
    gnt_data_s   = '0;
    next_state_s = state_r;

    // A full register may be refilled in the same cycle it drains.
    if (state_r == ST_EMPTY) begin
      can_load_s = 1'b1;
    end else begin
      can_load_s = bus.out_ready;
    end

    case ({bus.i1_valid, bus.i0_valid})
      2'b01: begin
        gnt_valid_s = 1'b1;
        gnt_s       = 1'b0;
      end
      2'b10: begin
        gnt_valid_s = 1'b1;
        gnt_s       = 1'b1;
      end
      2'b11: begin
        // Contention goes to whichever source did not win last time.
        gnt_valid_s = 1'b1;
        gnt_s       = ~last_r;
      end
      default: begin
        gnt_valid_s = 1'b0;
        gnt_s       = 1'b0;
      end
    endcase

    load_s = can_load_s && gnt_valid_s && !rst;

    if (gnt_s) begin
      gnt_data_s = bus.i1_data;
    end else begin
      gnt_data_s = bus.i0_data;
    end

    case (state_r)
      ST_EMPTY: begin
        if (load_s) begin
          next_state_s = ST_FULL;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          next_state_s = ST_FULL;
        end else if (bus.out_ready) begin
          next_state_s = ST_EMPTY;
        end else begin
          next_state_s = ST_FULL;
        end
      end
      default: begin
        next_state_s = ST_EMPTY;
      end
    endcase
  end

  assign bus.i0_ready  = load_s && !gnt_s;
  assign bus.i1_ready  = load_s && gnt_s;
  assign bus.out_valid = (state_r == ST_FULL);
  assign bus.out_data  = data_r;
  assign bus.sel       = sel_r;

  // Output register, source tag and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      data_r  <= '0;
      sel_r   <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        data_r <= gnt_data_s;
        sel_r  <= gnt_s;
        last_r <= gnt_s;
      end else begin
        data_r <= data_r;
        sel_r  <= sel_r;
        last_r <= last_r;
      end
    end
  end

endmodule
